// File: rtl/fe_pkg.sv
// -----------------------------------------------------------------------------
// fe_pkg
// Shared definitions for the UART bus peripheral: register offsets decoded
// from bus_addr[3:2], STATUS bit positions, the TX launch timeout and the
// TX launch FSM state type.
// -----------------------------------------------------------------------------
package fe_pkg;

    // Register offsets (bus_addr[3:2])
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit indices
    localparam int unsigned ST_TX_FULL    = 0;
    localparam int unsigned ST_TX_EMPTY   = 1;
    localparam int unsigned ST_RX_VALID   = 2;
    localparam int unsigned ST_RX_OVERRUN = 3;
    localparam int unsigned ST_TX_DROP    = 4;
    localparam int unsigned ST_UART_BUSY  = 5;

    // Cycles spent waiting for the transmitter to report busy after a launch
    localparam int unsigned BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LAUNCH,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head (first-word fall-through).
// A push while full and a pop while empty are ignored; a push while full is
// ignored even when a pop occurs in the same cycle.
//
// Ports
//   clk    in   clock, rising edge
//   n_rst  in   asynchronous active-low reset (empties the FIFO)
//   push   in   write wdata into the tail
//   wdata  in   WIDTH-bit data to write
//   pop    in   discard the head entry
//   rdata  out  current head entry
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
//   count  out  number of entries stored, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only entries between the pointers are visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_peripheral.sv
// -----------------------------------------------------------------------------
// uart_peripheral
// Bus-mapped front end for a byte UART: a TX FIFO drained by a launch FSM into
// the transmitter, and a single-byte RX holding register with overrun flag.
//
// Registers (bus_addr[3:2]):
//   0 TXDATA  write: push wrdata[7:0] (dropped and tx_drop set when full)
//   1 RXDATA  read : {24'b0, byte}; a selected read clears rx_valid
//   2 STATUS  read : [0] tx_full [1] tx_empty [2] rx_valid [3] rx_overrun
//                    [4] tx_drop [5] uart_busy; write-1-clear bits 3 and 4
//   3 reserved (reads 0, writes ignored)
//
// Ports
//   clk, n_rst                 clock and asynchronous active-low reset
//   per_sel                    bus access targets this block
//   bus_addr, bus_wren,
//   bus_rden, bus_wrdata       bus request
//   bus_rddata                 read data, combinational from bus_addr[3:2]
//   uart_tx_data, uart_tx_send byte and one-cycle launch pulse to transmitter
//   uart_busy                  transmitter busy flag
//   uart_rx_data, uart_rx_flag received byte and byte-ready flag
//   uart_rx_clear              one-cycle pulse acknowledging uart_rx_flag
// -----------------------------------------------------------------------------
module uart_peripheral
    import fe_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        per_sel,
    input  logic [31:0] bus_addr,
    input  logic        bus_wren,
    input  logic        bus_rden,
    input  logic [31:0] bus_wrdata,
    output logic [31:0] bus_rddata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_send,
    input  logic        uart_busy,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_flag,
    output logic        uart_rx_clear
);

    localparam logic [1:0] WAIT_LAST = 2'(BUSY_TIMEOUT - 1);

    // Bus decode
    logic [1:0] reg_sel;
    logic       wr_tx, wr_status, rd_rx;

    assign reg_sel   = bus_addr[3:2];
    assign wr_tx     = per_sel & bus_wren & (reg_sel == REG_TXDATA);
    assign wr_status = per_sel & bus_wren & (reg_sel == REG_STATUS);
    assign rd_rx     = per_sel & bus_rden & (reg_sel == REG_RXDATA);

    // TX FIFO
    logic                        fifo_pop;
    logic [7:0]                  fifo_head;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (wr_tx),
        .wdata (bus_wrdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    // TX launch FSM
    tx_state_e  state_q, state_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] tx_data_q, tx_data_d;

    // IDLE also requires uart_busy=0, which guarantees at least one idle
    // cycle of the transmitter between consecutive frames.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        tx_data_d    = tx_data_q;
        fifo_pop     = 1'b0;
        uart_tx_send = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty && !uart_busy) begin
                    fifo_pop  = 1'b1;
                    tx_data_d = fifo_head;
                    state_d   = TX_LAUNCH;
                end
            end
            TX_LAUNCH: begin
                uart_tx_send = 1'b1;
                wait_cnt_d   = '0;
                state_d      = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = TX_WAIT_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = TX_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            TX_WAIT_DONE: begin
                if (!uart_busy) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= TX_IDLE;
            wait_cnt_q <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign uart_tx_data = tx_data_q;

    // tx_drop: a hardware set in the same cycle as a clear wins.
    logic tx_drop_q, tx_drop_d;

    always_comb begin
        tx_drop_d = tx_drop_q;
        if (wr_status && bus_wrdata[ST_TX_DROP]) begin
            tx_drop_d = 1'b0;
        end
        if (wr_tx && fifo_full) begin
            tx_drop_d = 1'b1;
        end
    end

    // RX holding register
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       rx_clear_q, rx_clear_d;
    logic       rx_event;

    // uart_rx_flag is still high during the clear pulse; masking it there keeps
    // one delivered byte from being seen twice.
    assign rx_event = uart_rx_flag & ~rx_clear_q;

    // A read in the same cycle as a capture frees the holding register, so
    // the new byte is loaded without flagging an overrun.
    always_comb begin
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        rx_clear_d   = 1'b0;
        if (rd_rx) begin
            rx_valid_d = 1'b0;
        end
        if (wr_status && bus_wrdata[ST_RX_OVERRUN]) begin
            rx_overrun_d = 1'b0;
        end
        if (rx_event) begin
            rx_clear_d = 1'b1;
            if (!rx_valid_q || rd_rx) begin
                rx_byte_d  = uart_rx_data;
                rx_valid_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_clear_q   <= 1'b0;
            tx_drop_q    <= 1'b0;
        end else begin
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            rx_clear_q   <= rx_clear_d;
            tx_drop_q    <= tx_drop_d;
        end
    end

    assign uart_rx_clear = rx_clear_q;

    // Read mux
    logic [31:0] status;

    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = fifo_full;
        status[ST_TX_EMPTY]   = fifo_empty;
        status[ST_RX_VALID]   = rx_valid_q;
        status[ST_RX_OVERRUN] = rx_overrun_q;
        status[ST_TX_DROP]    = tx_drop_q;
        status[ST_UART_BUSY]  = uart_busy;
    end

    always_comb begin
        bus_rddata = '0;
        case (reg_sel)
            REG_RXDATA: bus_rddata = {24'b0, rx_byte_q};
            REG_STATUS: bus_rddata = status;
            default:    bus_rddata = '0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{bus_addr[31:4], bus_addr[1:0], bus_wrdata[31:8],
                           fifo_count_unused};

endmodule

// File: tb/tb_uart_peripheral.sv
// -----------------------------------------------------------------------------
// tb_uart_peripheral
// Directed bench for uart_peripheral (FIFO_DEPTH=4). A small transmitter model
// reacts to uart_tx_send on the falling edge and logs every launched byte with
// its cycle number.
// -----------------------------------------------------------------------------
module tb_uart_peripheral;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        per_sel = 1'b0;
    logic [31:0] bus_addr = '0;
    logic        bus_wren = 1'b0;
    logic        bus_rden = 1'b0;
    logic [31:0] bus_wrdata = '0;
    logic [31:0] bus_rddata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_send;
    logic        uart_busy = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_flag = 1'b0;
    logic        uart_rx_clear;

    uart_peripheral #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .per_sel       (per_sel),
        .bus_addr      (bus_addr),
        .bus_wren      (bus_wren),
        .bus_rden      (bus_rden),
        .bus_wrdata    (bus_wrdata),
        .bus_rddata    (bus_rddata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_send  (uart_tx_send),
        .uart_busy     (uart_busy),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_flag  (uart_rx_flag),
        .uart_rx_clear (uart_rx_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Transmitter model: mode 0 = busy for 10 cycles per launch,
    // mode 1 = busy held high, mode 2 = never busy.
    int         busy_mode = 0;
    int         busy_cnt = 0;
    int         cyc = 0;
    int         sent_n = 0;
    logic [7:0] sent_data [64];
    int         sent_time [64];
    int         dbl_err = 0;
    logic       prev_send = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (uart_tx_send === 1'b1) begin
            if (prev_send) dbl_err = dbl_err + 1;
            if (sent_n < 64) begin
                sent_data[sent_n] = uart_tx_data;
                sent_time[sent_n] = cyc;
            end
            sent_n = sent_n + 1;
        end
        prev_send = (uart_tx_send === 1'b1);
        if (busy_mode == 0 && uart_tx_send === 1'b1) busy_cnt = 10;
        else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        uart_busy = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'b0 : (busy_cnt != 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        per_sel = 1'b1; bus_wren = 1'b1; bus_addr = a; bus_wrdata = d;
        @(negedge clk);
        per_sel = 1'b0; bus_wren = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        per_sel = 1'b1; bus_rden = 1'b1; bus_addr = a;
        #1 d = bus_rddata;
        @(negedge clk);
        per_sel = 1'b0; bus_rden = 1'b0;
    endtask

    // STATUS via the combinational read path, no strobe.
    task automatic peek_status(output logic [31:0] d);
        bus_addr = 32'h8;
        #1 d = bus_rddata;
    endtask

    task automatic deliver_rx(input logic [7:0] b);
        @(negedge clk);
        uart_rx_data = b; uart_rx_flag = 1'b1;
        @(negedge clk);
        #1 check("rx_clear_pulse", {31'b0, uart_rx_clear}, 32'h1);
        uart_rx_flag = 1'b0;
        @(negedge clk);
        #1 check("rx_clear_end", {31'b0, uart_rx_clear}, 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        int base;

        // Reset state
        idle(2);
        #1;
        check("rst_send", {31'b0, uart_tx_send}, 32'h0);
        check("rst_txdata", {24'b0, uart_tx_data}, 32'h0);
        check("rst_rxclear", {31'b0, uart_rx_clear}, 32'h0);
        peek_status(d);
        check("rst_status", d, 32'h2);
        @(negedge clk);
        n_rst = 1'b1;
        idle(2);

        // Single byte with a 10-cycle busy transmitter
        base = sent_n;
        bus_write(32'h0, 32'h41);
        idle(30);
        #1;
        check("tx1_count", sent_n - base, 32'd1);
        check("tx1_byte", {24'b0, sent_data[base]}, 32'h41);
        check("tx1_data_hold", {24'b0, uart_tx_data}, 32'h41);
        peek_status(d);
        check("tx1_status", d, 32'h2);

        // Fill FIFO with transmitter held busy, overflow drops the fifth byte
        busy_mode = 1;
        idle(2);
        base = sent_n;
        for (int i = 1; i <= 5; i++) bus_write(32'h0, 32'(i));
        #1;
        peek_status(d);
        check("fill_status", d, 32'h31);
        check("fill_nolaunch", sent_n - base, 32'd0);
        busy_mode = 0;
        idle(80);
        #1;
        check("drain_count", sent_n - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_byte", {24'b0, sent_data[base + i]}, 32'(i + 1));
        end
        for (int i = 1; i < 4; i++) begin
            check("drain_gap", 32'(sent_time[base + i] - sent_time[base + i - 1]), 32'd12);
        end
        peek_status(d);
        check("drain_status", d, 32'h12);
        bus_write(32'h8, 32'h10);
        #1;
        peek_status(d);
        check("drop_cleared", d, 32'h2);

        // RX capture and read
        deliver_rx(8'h5A);
        peek_status(d);
        check("rx_valid_set", d, 32'h6);
        bus_read(32'h4, d);
        check("rx_read", d, 32'h5A);
        #1;
        peek_status(d);
        check("rx_valid_clr", d, 32'h2);

        // Overrun keeps the first byte
        deliver_rx(8'h11);
        deliver_rx(8'h22);
        peek_status(d);
        check("ovr_status", d, 32'hE);
        bus_read(32'h4, d);
        check("ovr_read", d, 32'h11);
        #1;
        peek_status(d);
        check("ovr_after_read", d, 32'hA);
        bus_write(32'h8, 32'h08);
        #1;
        peek_status(d);
        check("ovr_cleared", d, 32'h2);

        // Read and capture in the same cycle
        deliver_rx(8'h33);
        @(negedge clk);
        uart_rx_data = 8'h44; uart_rx_flag = 1'b1;
        per_sel = 1'b1; bus_rden = 1'b1; bus_addr = 32'h4;
        #1 check("same_rd_old", bus_rddata, 32'h33);
        @(negedge clk);
        per_sel = 1'b0; bus_rden = 1'b0;
        #1 check("same_clear", {31'b0, uart_rx_clear}, 32'h1);
        uart_rx_flag = 1'b0;
        peek_status(d);
        check("same_status", d, 32'h6);
        bus_read(32'h4, d);
        check("same_rd_new", d, 32'h44);
        #1;
        peek_status(d);
        check("same_final", d, 32'h2);

        // Strobes without per_sel; read+write together
        busy_mode = 1;
        idle(2);
        base = sent_n;
        @(negedge clk);
        bus_wren = 1'b1; bus_addr = 32'h0; bus_wrdata = 32'h77;
        @(negedge clk);
        bus_wren = 1'b0;
        #1;
        peek_status(d);
        check("nosel_status", d, 32'h22);
        deliver_rx(8'h55);
        deliver_rx(8'h66);
        @(negedge clk);
        per_sel = 1'b1; bus_rden = 1'b1; bus_wren = 1'b1;
        bus_addr = 32'h8; bus_wrdata = 32'h08;
        #1 check("rdwr_status", bus_rddata, 32'h2E);
        @(negedge clk);
        per_sel = 1'b0; bus_rden = 1'b0; bus_wren = 1'b0;
        #1;
        peek_status(d);
        check("rdwr_cleared", d, 32'h26);
        bus_read(32'h4, d);
        check("rdwr_rxbyte", d, 32'h55);
        busy_mode = 0;
        idle(5);
        #1;
        check("nosel_nolaunch", sent_n - base, 32'd0);

        // Transmitter never reports busy: timeout then next launch
        busy_mode = 2;
        idle(2);
        base = sent_n;
        bus_write(32'h0, 32'hA1);
        bus_write(32'h0, 32'hA2);
        idle(30);
        #1;
        check("tmo_count", sent_n - base, 32'd2);
        check("tmo_byte0", {24'b0, sent_data[base]}, 32'hA1);
        check("tmo_byte1", {24'b0, sent_data[base + 1]}, 32'hA2);
        check("tmo_gap", 32'(sent_time[base + 1] - sent_time[base]), 32'd6);

        // Reset in WAIT_DONE with three bytes queued
        busy_mode = 0;
        idle(2);
        base = sent_n;
        bus_write(32'h0, 32'hB1);
        bus_write(32'h0, 32'hB2);
        bus_write(32'h0, 32'hB3);
        bus_write(32'h0, 32'hB4);
        #1;
        check("mid_count", sent_n - base, 32'd1);
        n_rst = 1'b0;
        #1;
        check("mid_rst_send", {31'b0, uart_tx_send}, 32'h0);
        check("mid_rst_txdata", {24'b0, uart_tx_data}, 32'h0);
        check("mid_rst_rxclear", {31'b0, uart_rx_clear}, 32'h0);
        peek_status(d);
        check("mid_rst_status", d & 32'hFFFF_FFDF, 32'h2);
        idle(2);
        n_rst = 1'b1;
        idle(40);
        #1;
        check("post_rst_nolaunch", sent_n - base, 32'd1);
        bus_write(32'h0, 32'hC1);
        idle(30);
        #1;
        check("post_rst_count", sent_n - base, 32'd2);
        check("post_rst_byte", {24'b0, sent_data[base + 1]}, 32'hC1);
        check("post_rst_data", {24'b0, uart_tx_data}, 32'hC1);

        check("send_single_cycle", 32'(dbl_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_peripheral.md
UART_PERIPHERAL -- requirements
Module: uart_peripheral

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries, power of two, at least 2.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port per_sel  input  1  bus access targets this block this cycle.
REQ-005 SHALL have port bus_addr  input  32  byte address; only [3:2] decoded.
REQ-006 SHALL have port bus_wren  input  1  write strobe, valid only with per_sel.
REQ-007 SHALL have port bus_rden  input  1  read strobe, valid only with per_sel.
REQ-008 SHALL have port bus_wrdata  input  32  write data.
REQ-009 SHALL have port bus_rddata  output  32  read data, combinational from bus_addr[3:2].
REQ-010 SHALL have ports uart_tx_data (output, 8), uart_tx_send (output, 1) and uart_busy (input, 1); these are the byte, launch pulse and busy flag of the UART transmitter.
REQ-011 SHALL have ports uart_rx_data (input, 8), uart_rx_flag (input, 1) and uart_rx_clear (output, 1); these are the received byte, byte-ready flag and flag-clear pulse.

Function
REQ-012 Register map on bus_addr[3:2] SHALL be: 0 = TXDATA (write), 1 = RXDATA (read), 2 = STATUS (read/write-1-clear), 3 = reserved (reads 0, writes ignored).
REQ-013 STATUS SHALL be: [0] tx_full, [1] tx_empty, [2] rx_valid, [3] rx_overrun, [4] tx_drop, [5] uart_busy; [31:6] = 0.
REQ-014 Writing STATUS SHALL clear bit 3 if wrdata[3]=1 and bit 4 if wrdata[4]=1; other bits are unaffected.
REQ-015 Writing TXDATA with the FIFO not full SHALL push wrdata[7:0]; with the FIFO full SHALL drop the byte and set tx_drop, even if a pop occurs in the same cycle.
REQ-016 A push and a pop in the same cycle with the FIFO not full SHALL both take effect, leaving the count unchanged.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL have width log2(FIFO_DEPTH)+1.
REQ-018 The TX FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-019 IDLE->LAUNCH: when the FIFO is not empty and uart_busy=0, pop the head into the uart_tx_data register.
REQ-020 LAUNCH: uart_tx_send=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-021 WAIT_BUSY->WAIT_DONE when uart_busy=1; if uart_busy is not seen within 4 cycles, go to IDLE (timeout).
REQ-022 WAIT_DONE->IDLE when uart_busy=0.
REQ-023 uart_tx_data SHALL hold its value from LAUNCH until the next LAUNCH.
REQ-024 Back-to-back bytes SHALL be spaced no tighter than one cycle of uart_busy=0 between frames.
REQ-025 When uart_rx_flag=1 and rx_valid=0, the block SHALL capture uart_rx_data, set rx_valid and pulse uart_rx_clear for one cycle.
REQ-026 When uart_rx_flag=1 and rx_valid=1, the block SHALL keep the held byte, set rx_overrun and pulse uart_rx_clear.
REQ-027 Reading RXDATA (per_sel & bus_rden) SHALL return {24'b0, byte} and clear rx_valid next cycle.
REQ-028 An RXDATA read and a new capture in the same cycle SHALL return the old byte, load the new byte, keep rx_valid=1 and NOT set overrun.
REQ-029 Strobes without per_sel SHALL have no effect; bus_rden and bus_wren together SHALL apply both.

Reset
REQ-030 n_rst=0 SHALL asynchronously produce: FIFO empty, pointers 0, FSM IDLE, uart_tx_data=0, uart_tx_send=0, uart_rx_clear=0, rx byte=0, rx_valid=0, rx_overrun=0, tx_drop=0.
REQ-031 Reset mid-frame SHALL abandon queued bytes; no uart_tx_send pulse SHALL follow release until a new TXDATA write.

Structure
REQ-032 fe_pkg SHALL hold the register offset constants, STATUS bit indices and the TX FSM state enum.
REQ-033 The TX FIFO SHALL be one sub-module, sync_fifo (parameter DEPTH, WIDTH=8, full/empty/count outputs); all other logic SHALL be inline.

Verification
REQ-034 Write TXDATA 0x41 with uart_busy modelled at 10 cycles: exactly one uart_tx_send pulse, uart_tx_data=0x41, STATUS tx_empty=1 afterwards.
REQ-035 Hold uart_busy=1 and write 0x01..0x05 (FIFO_DEPTH=4): tx_full=1, 0x05 dropped, tx_drop=1; release busy and observe 0x01..0x04 in order.
REQ-036 Raise uart_rx_flag with 0x5A, then read RXDATA: uart_rx_clear one-cycle pulse, read returns 0x0000005A, rx_valid=0 next cycle.
REQ-037 Deliver 0x11 then 0x22 with no read: RXDATA=0x11, rx_overrun=1; write STATUS 0x08 and confirm rx_overrun=0.
REQ-038 Never assert uart_busy after LAUNCH: FSM returns to IDLE after 4 cycles and the next byte launches.
REQ-039 Assert n_rst=0 in WAIT_DONE with 3 bytes queued: all outputs at reset values immediately, and no launch after release.
